// File: rtl/systolic_pkg.sv
// Shared sizing helpers and types for the systolic feeder datapath.
package systolic_pkg;

   typedef logic bank_t;

   function automatic int tile_max_f(input int max_size);
      return max_size * max_size;
   endfunction

   function automatic int addr_w_f(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int size_w_f(input int max_size);
      return $clog2(max_size) + 1;
   endfunction

endpackage

// File: rtl/feeder_buffer_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port
// whose output holds when no read is requested.
module feeder_buffer_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2048,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Storage array write port; contents are deliberately never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= {DATA_WIDTH{1'b0}};
      end else if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/feeder_tile_buffer.sv
// Double-banked tile store: the host fills one bank while the feeder reads the
// other through tile-relative addresses with one cycle of read latency.
module feeder_tile_buffer
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIF0_DEPTH = 2048,
   parameter int MAX_SIZE   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rst_flush,
   input  logic [$clog2(MAX_SIZE):0]     matrix_size,
   input  logic                          wr_valid,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   output logic                          wr_ready,
   input  logic [$clog2(FIF0_DEPTH)-1:0] fifo_addr,
   input  logic                          completed,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic                          data_valid,
   output logic                          tile_ready,
   output logic [1:0]                    banks_full
);

   localparam int TILE_LEN = tile_max_f(MAX_SIZE);
   localparam int AW       = addr_w_f(FIF0_DEPTH);
   localparam int SW       = size_w_f(MAX_SIZE);

   logic [1:0]    full_r;
   logic [1:0]    full_nxt_s;
   bank_t         wb_r;
   bank_t         rb_r;
   logic [AW-1:0] wr_cnt_r;
   logic [SW-1:0] bsize_r [2];
   logic          data_valid_r;

   logic [SW-1:0] eff_size_s;
   logic [SW-1:0] cur_size_s;
   logic [AW:0]   wr_lim_s;
   logic [AW:0]   rd_lim_s;
   logic          wr_ready_s;
   logic          wr_fire_s;
   logic          wr_first_s;
   logic          wr_last_s;
   logic          cpl_fire_s;
   logic          rd_hit_s;
   logic [AW-1:0] wr_addr_s;
   logic [AW-1:0] rd_addr_s;

   // Size clamp, handshake, tile-end detection and bank address formation.
   always_comb begin
      if (matrix_size > SW'(MAX_SIZE)) begin
         eff_size_s = SW'(MAX_SIZE);
      end else begin
         eff_size_s = matrix_size;
      end
      wr_first_s = (wr_cnt_r == {AW{1'b0}});
      // The first element of a tile uses the live size; later ones the latched one.
      if (wr_first_s) begin
         cur_size_s = eff_size_s;
      end else begin
         cur_size_s = bsize_r[wb_r];
      end
      wr_lim_s   = (AW+1)'(cur_size_s) * (AW+1)'(cur_size_s);
      rd_lim_s   = (AW+1)'(bsize_r[rb_r]) * (AW+1)'(bsize_r[rb_r]);
      wr_ready_s = !full_r[wb_r] && (eff_size_s != {SW{1'b0}}) && !rst_flush;
      wr_fire_s  = wr_valid && wr_ready_s;
      wr_last_s  = wr_fire_s && ({1'b0, wr_cnt_r} == (wr_lim_s - (AW+1)'(1)));
      cpl_fire_s = completed && full_r[rb_r] && !rst_flush;
      rd_hit_s   = full_r[rb_r] && ({1'b0, fifo_addr} < rd_lim_s) && !rst_flush;
      wr_addr_s  = (wb_r ? AW'(TILE_LEN) : {AW{1'b0}}) + wr_cnt_r;
      rd_addr_s  = (rb_r ? AW'(TILE_LEN) : {AW{1'b0}}) + fifo_addr;
   end

   // Next bank-full flags; release and fill always target different banks.
   always_comb begin
      full_nxt_s = full_r;
      if (cpl_fire_s) begin
         full_nxt_s[rb_r] = 1'b0;
      end else begin
         full_nxt_s[rb_r] = full_r[rb_r];
      end
      if (wr_last_s) begin
         full_nxt_s[wb_r] = 1'b1;
      end else begin
         full_nxt_s[wb_r] = full_nxt_s[wb_r];
      end
   end

   // Bank pointers, write counter, latched sizes and read-valid pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_r       <= 2'b00;
         wb_r         <= 1'b0;
         rb_r         <= 1'b0;
         wr_cnt_r     <= {AW{1'b0}};
         bsize_r[0]   <= {SW{1'b0}};
         bsize_r[1]   <= {SW{1'b0}};
         data_valid_r <= 1'b0;
      end else if (rst_flush) begin
         full_r       <= 2'b00;
         wb_r         <= 1'b0;
         rb_r         <= 1'b0;
         wr_cnt_r     <= {AW{1'b0}};
         data_valid_r <= 1'b0;
      end else begin
         full_r       <= full_nxt_s;
         data_valid_r <= rd_hit_s;
         if (wr_fire_s && wr_first_s) begin
            bsize_r[wb_r] <= eff_size_s;
         end
         if (wr_last_s) begin
            wb_r     <= ~wb_r;
            wr_cnt_r <= {AW{1'b0}};
         end else if (wr_fire_s) begin
            wr_cnt_r <= wr_cnt_r + AW'(1);
         end
         if (cpl_fire_s) begin
            rb_r <= ~rb_r;
         end
      end
   end

   feeder_buffer_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIF0_DEPTH),
      .ADDR_W     (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_fire_s),
      .wr_addr (wr_addr_s),
      .wr_data (wr_data),
      .rd_en   (rd_hit_s),
      .rd_addr (rd_addr_s),
      .rd_data (data_in)
   );

   assign wr_ready   = wr_ready_s;
   assign data_valid = data_valid_r;
   assign tile_ready = full_r[rb_r];
   assign banks_full = {1'b0, full_r[0]} + {1'b0, full_r[1]};

endmodule

// File: tb/tb_feeder_tile_buffer.sv
// Directed bench for feeder_tile_buffer: fill/read, ping-pong, boundaries,
// coincident events, flush, async reset and size clamping.
module tb_feeder_tile_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_flush = 1'b0;
   logic [4:0]  matrix_size = 5'd4;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_data = 32'd0;
   logic        wr_ready;
   logic [10:0] fifo_addr = 11'd0;
   logic        completed = 1'b0;
   logic [31:0] data_in;
   logic        data_valid;
   logic        tile_ready;
   logic [1:0]  banks_full;

   int checks = 0;
   int failures = 0;

   feeder_tile_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .rst_flush   (rst_flush),
      .matrix_size (matrix_size),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .fifo_addr   (fifo_addr),
      .completed   (completed),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .tile_ready  (tile_ready),
      .banks_full  (banks_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int base, input int count);
      for (int i = 0; i < count; i++) begin
         wr_valid = 1'b1;
         wr_data  = 32'(base + i);
         tick();
      end
      wr_valid = 1'b0;
   endtask

   task automatic rd(input string tag, input int addr, input logic exp_v, input int exp_d);
      fifo_addr = 11'(addr);
      tick();
      chk({tag, "_valid"}, {31'd0, data_valid}, {31'd0, exp_v});
      if (exp_v) chk({tag, "_data"}, data_in, 32'(exp_d));
   endtask

   initial begin
      #3;
      chk("rst_valid", {31'd0, data_valid}, 32'd0);
      chk("rst_data", data_in, 32'd0);
      chk("rst_tile", {31'd0, tile_ready}, 32'd0);
      chk("rst_banks", {30'd0, banks_full}, 32'd0);
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      tick();
      rst = 1'b0;

      rd("empty_rd", 0, 1'b0, 0);

      fill(0, 15);
      chk("fill15_tile", {31'd0, tile_ready}, 32'd0);
      fill(15, 1);
      chk("fill16_tile", {31'd0, tile_ready}, 32'd1);
      chk("fill16_banks", {30'd0, banks_full}, 32'd1);
      for (int a = 0; a < 16; a++) rd("sweep", a, 1'b1, a);
      rd("oor16", 16, 1'b0, 0);
      chk("oor16_hold", data_in, 32'd15);

      matrix_size = 5'd2;
      fill(100, 4);
      chk("pp_banks", {30'd0, banks_full}, 32'd2);
      chk("pp_wr_ready", {31'd0, wr_ready}, 32'd0);
      completed = 1'b1;
      tick();
      completed = 1'b0;
      chk("pp_cpl_banks", {30'd0, banks_full}, 32'd1);
      chk("pp_cpl_wr_ready", {31'd0, wr_ready}, 32'd1);
      rd("pp_rd3", 3, 1'b1, 103);
      rd("pp_rd4", 4, 1'b0, 0);

      completed = 1'b1;
      tick();
      completed = 1'b0;
      chk("empty_banks", {30'd0, banks_full}, 32'd0);
      completed = 1'b1;
      tick();
      completed = 1'b0;
      chk("idle_cpl_banks", {30'd0, banks_full}, 32'd0);

      matrix_size = 5'd4;
      fill(300, 16);
      matrix_size = 5'd2;
      fill(400, 3);
      chk("sim_pre_banks", {30'd0, banks_full}, 32'd1);
      wr_valid  = 1'b1;
      wr_data   = 32'd403;
      completed = 1'b1;
      tick();
      wr_valid  = 1'b0;
      completed = 1'b0;
      chk("sim_banks", {30'd0, banks_full}, 32'd1);
      chk("sim_tile", {31'd0, tile_ready}, 32'd1);
      chk("sim_wr_ready", {31'd0, wr_ready}, 32'd1);
      rd("sim_rb1", 3, 1'b1, 403);
      rd("sim_rb1_a0", 0, 1'b1, 400);

      matrix_size = 5'd4;
      fill(500, 7);
      rst_flush = 1'b1;
      wr_valid  = 1'b1;
      wr_data   = 32'd999;
      completed = 1'b1;
      #1;
      chk("flush_wr_ready", {31'd0, wr_ready}, 32'd0);
      tick();
      rst_flush = 1'b0;
      wr_valid  = 1'b0;
      completed = 1'b0;
      chk("flush_valid", {31'd0, data_valid}, 32'd0);
      chk("flush_banks", {30'd0, banks_full}, 32'd0);
      chk("flush_hold", data_in, 32'd400);
      fill(600, 15);
      chk("flush15_tile", {31'd0, tile_ready}, 32'd0);
      fill(615, 1);
      chk("flush16_tile", {31'd0, tile_ready}, 32'd1);
      rd("flush_rd0", 0, 1'b1, 600);
      rd("flush_rd15", 15, 1'b1, 615);

      rd("prerst_rd1", 1, 1'b1, 601);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", {31'd0, data_valid}, 32'd0);
      chk("arst_data", data_in, 32'd0);
      chk("arst_tile", {31'd0, tile_ready}, 32'd0);
      chk("arst_banks", {30'd0, banks_full}, 32'd0);
      tick();
      rst = 1'b0;

      matrix_size = 5'd0;
      #1;
      chk("n0_wr_ready", {31'd0, wr_ready}, 32'd0);
      matrix_size = 5'd20;
      #1;
      chk("n20_wr_ready", {31'd0, wr_ready}, 32'd1);
      fill(0, 255);
      chk("n20_255_tile", {31'd0, tile_ready}, 32'd0);
      fill(255, 1);
      chk("n20_256_tile", {31'd0, tile_ready}, 32'd1);
      rd("n20_rd255", 255, 1'b1, 255);
      rd("n20_rd256", 256, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/feeder_tile_buffer.md
# feeder_tile_buffer

Double-banked source memory that answers the address-driven reads of `data_feeder`. A host side streams matrix elements in with a valid/ready handshake. The feeder side presents a tile-relative `fifo_addr` and receives `data_in`/`data_valid` one cycle later. The feeder's `completed` pulse releases the bank it was reading, so the host can fill one tile while the systolic array consumes the other.

## Interface
- `DATA_WIDTH`, 32: element width.
- `FIF0_DEPTH`, 2048: physical words; must be ≥ 2·MAX_SIZE².
- `MAX_SIZE`, 16: largest matrix dimension; bank stride `TILE_MAX` = MAX_SIZE².

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rst_flush`  in  1: synchronous flush of all control state.
- `matrix_size`  in  $clog2(MAX_SIZE)+1: N for the tile being written.
- `wr_valid`  in  1: host element valid.
- `wr_data`  in  DATA_WIDTH: host element, row-major.
- `wr_ready`  out  1: host element accepted when `wr_valid && wr_ready`.
- `fifo_addr`  in  $clog2(FIF0_DEPTH): tile-relative read address from the feeder.
- `completed`  in  1: one-cycle pulse from the feeder; releases the read bank.
- `data_in`  out  DATA_WIDTH: read data to the feeder.
- `data_valid`  out  1: `data_in` is valid.
- `tile_ready`  out  1: read bank holds a complete tile.
- `banks_full`  out  2: number of full banks, 0 to 2.

## Operation
- State:
  - `full[1:0]`, one flag per bank.
  - Write bank pointer `wb` and read bank pointer `rb`.
  - Write counter `wr_cnt`.
  - Per-bank latched size `bsize[b]`.
- Size handling:
  - The effective size is `matrix_size` clamped to MAX_SIZE.
  - Size 0 forces `wr_ready`=0.
  - `bsize[wb]` latches on the accepted write with `wr_cnt`==0. The size is ignored for the rest of that tile.
- Write side:
  - `wr_ready` = !full[wb] && size≠0 && !rst_flush.
  - Each accepted write stores to physical address wb·TILE_MAX + wr_cnt, then increments `wr_cnt`.
  - When the write with `wr_cnt`==bsize²−1 is accepted: set `full[wb]`, toggle `wb`, clear `wr_cnt`.
- Read side, registered every cycle:
  - If `full[rb]` and `fifo_addr` < bsize[rb]²: `data_in` ← mem[rb·TILE_MAX + fifo_addr] and `data_valid` ← 1.
  - Otherwise `data_valid` ← 0 and `data_in` holds its previous value.
- Completion:
  - `completed` while `full[rb]`: clear `full[rb]`, toggle `rb`.
  - `completed` while `!full[rb]`: ignored.
- Status outputs:
  - `tile_ready` = full[rb].
  - `banks_full` = full[0]+full[1].
- Flush: `rst_flush` clears `full`, `wb`, `rb`, `wr_cnt` and `data_valid`. Memory contents are not cleared.

## Timing
- Reset values:
  - `data_valid`=0, `data_in`=0, `tile_ready`=0, `banks_full`=0.
  - `wr_ready` = (size≠0).
  - `wb`=`rb`=0, `wr_cnt`=0.
- Read latency is 1 cycle: an address sampled at edge k produces data at edge k+1, fully pipelined.
- Last write to edge: the last accepted write's edge sets `tile_ready`. The first valid read is the following cycle.
- Completion reaches the write side in 1 cycle: `completed` at edge k clears the flag, and `wr_ready` for that bank rises after edge k.
- Last write and `completed` in the same cycle:
  - This always involves different banks; both take effect.
  - `banks_full` is unchanged.
- `completed` can never coincide with a write into the same bank: that bank is full, so `wr_ready`=0.
- Both banks full: `wr_ready`=0 until `completed` arrives.
- Mid-operation events:
  - `rst` asserted mid-tile: all state clears immediately.
  - `rst_flush` with `wr_valid`=1: the write is not accepted.
  - `rst_flush` takes priority over `completed`.

## Structure
- Shared package `systolic_pkg` holds:
  - `TILE_MAX`, `ADDR_W` and `SIZE_W` derivations.
  - The bank-index typedef.
- One sub-module, `feeder_buffer_ram`: simple dual-port RAM with 1 write port and 1 registered read port, depth FIF0_DEPTH. The control logic lives in `feeder_tile_buffer`.

## Test plan
- Basic fill and read:
  - Stimulus: reset, N=4, write 0..15, then sweep `fifo_addr` 0..15.
  - Required: `tile_ready` after the 16th write; `data_in`=addr one cycle later with `data_valid`=1.
- Ping-pong:
  - Stimulus: fill bank 0 (N=4) and bank 1 (N=2, values 100..103).
  - Required:
    - `banks_full`=2 and `wr_ready`=0.
    - After `completed`, a read of addr 3 returns 103 and addr 4 gives `data_valid`=0.
- Out-of-range and empty:
  - Stimulus: read addr 0 with no full bank, then addr 16 with N=4 full.
  - Required: `data_valid`=0 in both cases.
- Simultaneous events:
  - Stimulus: bank 0 full, last write of bank 1 in the same cycle as `completed`.
  - Required: `banks_full` stays 1; `rb`=1; `tile_ready`=1.
- Flush and reset:
  - Stimulus: assert `rst_flush` after 7 writes; separately pulse `rst` mid-read.
  - Required:
    - Flush: `wr_cnt`=0 and a new full tile of 16 writes is needed.
    - Reset: `data_valid` drops to 0 asynchronously.
- Size edge cases:
  - Stimulus: N=0, then N=20 (clamped to 16).
  - Required: N=0 gives `wr_ready`=0; N=20 sets `tile_ready` after 256 writes.
